avalon_pio_in_debounced: RTL and testbench

Parametrised Avalon-MM input PIO, successor to the fixed-width switch-input PIO in the QSYS system. It samples WIDTH asynchronous inputs through a configurable synchronizer. Each channel then passes through a per-channel debounce filter that can be bypassed. Debounced transitions of the selected edge type set write-1-to-clear capture bits, which raise a maskable level interrupt to the HPS/Nios.

---
 rtl/avalon_pio_in_debounced.sv | 219 +++++++++++++++++++++
 tb/tb_avalon_pio_in_debounced.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_pio_in_debounced.sv
// ---------------------------------------------------------------------------
// avalon_pio_in_debounced
//
// Avalon-MM input PIO with per-channel synchronizer, debounce filter and
// edge-capture interrupt. Each of the WIDTH inputs goes through a chain of
// SYNC_STAGES flops. It then goes through a debounce filter that can be
// bypassed per channel. Debounced transitions of the selected polarity set
// write-1-to-clear capture bits. Those bits raise a maskable level interrupt.
//
// Register map (word address, read latency 1):
//   0 DATA          debounced state, read-only
//   1 RAW           synchronized input (last sync stage), read-only
//   2 IRQ_MASK      read/write
//   3 EDGE_CAPTURE  read, write-1-to-clear
//   4 DB_EN         per-channel debounce enable, read/write (resets to ones)
//   others          read 0, writes ignored
//
// Ports:
//   clk         system clock
//   reset_n     synchronous active-low reset
//   address     Avalon word address
//   chipselect  Avalon chipselect
//   write_n     Avalon write strobe, active-low
//   writedata   Avalon write data (bits above WIDTH ignored)
//   readdata    Avalon read data, registered every clock
//   irq         level interrupt, active-high
//   in_port     asynchronous external inputs
//
// Parameters:
//   WIDTH            number of channels (1..32)
//   SYNC_STAGES      synchronizer depth (>=2)
//   DEBOUNCE_CYCLES  cycles a change must persist before db follows (>=1)
//   EDGE_TYPE        0 = rising, 1 = falling, 2 = any edge
// ---------------------------------------------------------------------------
module avalon_pio_in_debounced #(
   parameter int WIDTH           = 10,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int EDGE_TYPE       = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [2:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   output logic             irq,
   input  logic [WIDTH-1:0] in_port
);

   // Counter only has to reach DEBOUNCE_CYCLES-1, so clog2 bits suffice.
   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   localparam logic [2:0] ADDR_DATA     = 3'd0;
   localparam logic [2:0] ADDR_RAW      = 3'd1;
   localparam logic [2:0] ADDR_IRQ_MASK = 3'd2;
   localparam logic [2:0] ADDR_CAPTURE  = 3'd3;
   localparam logic [2:0] ADDR_DB_EN    = 3'd4;

   // ------------------------------------------------------------------
   // Synchronizer chain
   // ------------------------------------------------------------------
   logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
   logic [WIDTH-1:0]                  sync_s;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sync_q <= '0;
      end else begin
         sync_q[0] <= in_port;
         for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_q[k] <= sync_q[k-1];
         end
      end
   end

   assign sync_s = sync_q[SYNC_STAGES-1];

   // ------------------------------------------------------------------
   // Register file state
   // ------------------------------------------------------------------
   logic [WIDTH-1:0] db_q;
   logic [WIDTH-1:0] db_d;
   logic [WIDTH-1:0] db_en_q;
   logic [WIDTH-1:0] db_en_d;
   logic [WIDTH-1:0] irq_mask_q;
   logic [WIDTH-1:0] irq_mask_d;
   logic [WIDTH-1:0] edge_capture_q;
   logic [WIDTH-1:0] edge_capture_d;
   logic [WIDTH-1:0] ev;
   logic [31:0]      readdata_q;
   logic [31:0]      readdata_d;

   // ------------------------------------------------------------------
   // Per-channel debounce filter
   // ------------------------------------------------------------------
   // The counter measures how many consecutive cycles the synchronized
   // input has disagreed with db. Any agreement (a bounce back) clears it.
   // With the filter bypassed, db tracks the synchronizer every cycle and
   // the counter sits at zero. Re-enabling therefore always starts a
   // fresh count.
   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_chan
         logic [CNT_W-1:0] cnt_q;
         logic [CNT_W-1:0] cnt_d;
         logic             db_nxt;

         always_comb begin
            cnt_d  = '0;
            db_nxt = db_q[gi];
            if (!db_en_q[gi]) begin
               db_nxt = sync_s[gi];
            end else if (sync_s[gi] != db_q[gi]) begin
               if (cnt_q == CNT_LAST) begin
                  db_nxt = sync_s[gi];
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end

         always_ff @(posedge clk) begin
            if (!reset_n) begin
               cnt_q <= '0;
            end else begin
               cnt_q <= cnt_d;
            end
         end

         assign db_d[gi] = db_nxt;
      end
   endgenerate

   // ------------------------------------------------------------------
   // Edge detection on the debounced value: fires in the cycle db is
   // about to change, so the capture bit sets on the same edge as db.
   // ------------------------------------------------------------------
   generate
      if (EDGE_TYPE == 0) begin : g_ev_rise
         assign ev = db_d & ~db_q;
      end else if (EDGE_TYPE == 1) begin : g_ev_fall
         assign ev = ~db_d & db_q;
      end else begin : g_ev_any
         assign ev = db_d ^ db_q;
      end
   endgenerate

   // ------------------------------------------------------------------
   // Avalon write decode
   // ------------------------------------------------------------------
   logic             wr_en;
   logic [WIDTH-1:0] wdata;
   logic             unused_wdata;

   assign wr_en = chipselect & ~write_n;
   assign wdata = writedata[WIDTH-1:0];
   // Upper write-data bits carry no meaning for narrow configurations.
   assign unused_wdata = ^writedata;

   always_comb begin
      irq_mask_d     = irq_mask_q;
      db_en_d        = db_en_q;
      edge_capture_d = edge_capture_q;

      if (wr_en && (address == ADDR_IRQ_MASK)) begin
         irq_mask_d = wdata;
      end
      if (wr_en && (address == ADDR_DB_EN)) begin
         db_en_d = wdata;
      end
      if (wr_en && (address == ADDR_CAPTURE)) begin
         edge_capture_d = edge_capture_q & ~wdata;
      end
      // OR-ing events in after the clear lets a coincident event win
      // over a W1C on the same bit, so no edge is ever lost.
      edge_capture_d = edge_capture_d | ev;
   end

   // ------------------------------------------------------------------
   // Read mux, registered every clock regardless of chipselect
   // ------------------------------------------------------------------
   always_comb begin
      readdata_d = '0;
      case (address)
         ADDR_DATA:     readdata_d[WIDTH-1:0] = db_q;
         ADDR_RAW:      readdata_d[WIDTH-1:0] = sync_s;
         ADDR_IRQ_MASK: readdata_d[WIDTH-1:0] = irq_mask_q;
         ADDR_CAPTURE:  readdata_d[WIDTH-1:0] = edge_capture_q;
         ADDR_DB_EN:    readdata_d[WIDTH-1:0] = db_en_q;
         default:       readdata_d = '0;
      endcase
   end

   // ------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         db_q           <= '0;
         db_en_q        <= '1;
         irq_mask_q     <= '0;
         edge_capture_q <= '0;
         readdata_q     <= '0;
      end else begin
         db_q           <= db_d;
         db_en_q        <= db_en_d;
         irq_mask_q     <= irq_mask_d;
         edge_capture_q <= edge_capture_d;
         readdata_q     <= readdata_d;
      end
   end

   assign readdata = readdata_q;
   assign irq      = |(edge_capture_q & irq_mask_q);

endmodule

// File: tb/tb_avalon_pio_in_debounced.sv
// ---------------------------------------------------------------------------
// tb_avalon_pio_in_debounced
//
// Directed bench for avalon_pio_in_debounced. Instance dut uses the default
// any-edge capture. Instance dut0 uses rising-edge capture and has its own
// chipselect, reset and inputs. Expected values are hand-derived constants.
// ---------------------------------------------------------------------------
module tb_avalon_pio_in_debounced;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        reset_n0;
   logic [2:0]  address;
   logic        chipselect;
   logic        chipselect0;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic [31:0] readdata0;
   logic        irq;
   logic        irq0;
   logic [9:0]  in_port;
   logic [9:0]  in_port0;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   avalon_pio_in_debounced #(
      .WIDTH(10), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(16), .EDGE_TYPE(2)
   ) dut (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .readdata(readdata),
      .irq(irq), .in_port(in_port)
   );

   avalon_pio_in_debounced #(
      .WIDTH(10), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(16), .EDGE_TYPE(0)
   ) dut0 (
      .clk(clk), .reset_n(reset_n0), .address(address), .chipselect(chipselect0),
      .write_n(write_n), .writedata(writedata), .readdata(readdata0),
      .irq(irq0), .in_port(in_port0)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // sel[0] selects dut, sel[1] selects dut0
   task automatic bus_wr(input logic [1:0] sel, input logic [2:0] a, input logic [31:0] d);
      address     = a;
      writedata   = d;
      write_n     = 1'b0;
      chipselect  = sel[0];
      chipselect0 = sel[1];
      tick();
      write_n     = 1'b1;
      chipselect  = 1'b0;
      chipselect0 = 1'b0;
      writedata   = '0;
      $display("write sel=%0d addr=%0d data=0x%08h", sel, a, d);
   endtask

   task automatic bus_rd(input logic [2:0] a);
      address = a;
      tick();
      $display("read addr=%0d dut=0x%08h dut0=0x%08h", a, readdata, readdata0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n     = 1'b0;
      reset_n0    = 1'b0;
      address     = '0;
      chipselect  = 1'b0;
      chipselect0 = 1'b0;
      write_n     = 1'b1;
      writedata   = '0;
      in_port     = '0;
      in_port0    = '0;
      repeat (3) tick();
      check_eq("rst_readdata", readdata, 32'h0);
      check_eq("rst_irq", {31'b0, irq}, 32'h0);
      check_eq("rst_readdata0", readdata0, 32'h0);
      reset_n  = 1'b1;
      reset_n0 = 1'b1;

      // reset values of the register file
      bus_rd(3'd4); check_eq("rst_db_en", readdata, 32'h3FF);
      check_eq("rst_db_en0", readdata0, 32'h3FF);
      bus_rd(3'd2); check_eq("rst_mask", readdata, 32'h0);
      bus_rd(3'd3); check_eq("rst_capture", readdata, 32'h0);
      bus_rd(3'd5); check_eq("unlisted_addr", readdata, 32'h0);

      // ---------------- rising-only instance ----------------
      in_port0[5] = 1'b1;
      address = 3'd0;
      repeat (18) tick();
      check_eq("e0_rise_lag", readdata0, 32'h0);
      tick();
      check_eq("e0_rise_data", readdata0, 32'h020);
      bus_rd(3'd3); check_eq("e0_rise_cap", readdata0, 32'h020);
      bus_wr(2'b10, 3'd3, 32'h020);
      bus_rd(3'd3); check_eq("e0_w1c", readdata0, 32'h0);
      in_port0[5] = 1'b0;
      address = 3'd0;
      repeat (18) tick();
      check_eq("e0_fall_lag", readdata0, 32'h020);
      tick();
      check_eq("e0_fall_data", readdata0, 32'h0);
      bus_rd(3'd3); check_eq("e0_fall_nocap", readdata0, 32'h0);
      check_eq("e0_irq", {31'b0, irq0}, 32'h0);

      // reset in the middle of a debounce count
      bus_wr(2'b10, 3'd2, 32'h3FF);
      bus_wr(2'b10, 3'd4, 32'h1FF);
      bus_rd(3'd4); check_eq("e0_db_en_wr", readdata0, 32'h1FF);
      in_port0[5] = 1'b1;
      repeat (9) tick();
      reset_n0 = 1'b0;
      repeat (2) tick();
      check_eq("e0_rst_rd", readdata0, 32'h0);
      check_eq("e0_rst_irq", {31'b0, irq0}, 32'h0);
      reset_n0 = 1'b1;
      address = 3'd4; tick();
      check_eq("e0_rst_db_en", readdata0, 32'h3FF);
      address = 3'd2; tick();
      check_eq("e0_rst_mask", readdata0, 32'h0);
      address = 3'd3; tick();
      check_eq("e0_rst_cap", readdata0, 32'h0);
      address = 3'd0;
      repeat (15) tick();
      check_eq("e0_restart_lag", readdata0, 32'h0);
      tick();
      check_eq("e0_restart_data", readdata0, 32'h020);

      // ---------------- any-edge instance ----------------
      bus_wr(2'b01, 3'd2, 32'hFFFF_FC01);
      bus_rd(3'd2); check_eq("mask_upper_ign", readdata, 32'h001);

      in_port[0] = 1'b1;
      address = 3'd0;
      repeat (17) tick();
      check_eq("irq_before", {31'b0, irq}, 32'h0);
      tick();
      check_eq("irq_edge18", {31'b0, irq}, 32'h1);
      check_eq("data_lag", readdata, 32'h0);
      tick();
      check_eq("data_bit0", readdata, 32'h001);
      bus_rd(3'd3); check_eq("cap_bit0", readdata, 32'h001);
      bus_wr(2'b01, 3'd0, 32'h0);
      bus_rd(3'd0); check_eq("data_ro", readdata, 32'h001);

      // W1C
      in_port[1] = 1'b1;
      repeat (20) tick();
      bus_rd(3'd3); check_eq("cap_0x3", readdata, 32'h003);
      bus_wr(2'b01, 3'd3, 32'h001);
      check_eq("irq_w1c", {31'b0, irq}, 32'h0);
      bus_rd(3'd3); check_eq("w1c_one", readdata, 32'h002);
      bus_wr(2'b01, 3'd3, 32'h000);
      bus_rd(3'd3); check_eq("w1c_zero", readdata, 32'h002);

      // glitch shorter than the debounce window
      address = 3'd1;
      in_port[3] = 1'b1;
      repeat (2) tick();
      check_eq("raw_pre", readdata, 32'h003);
      tick();
      check_eq("raw_bit3", readdata, 32'h00B);
      repeat (7) tick();
      in_port[3] = 1'b0;
      repeat (20) tick();
      bus_rd(3'd0); check_eq("glitch_data", readdata, 32'h003);
      bus_rd(3'd3); check_eq("glitch_cap", readdata, 32'h002);
      check_eq("glitch_irq", {31'b0, irq}, 32'h0);

      // W1C colliding with a capture on the same bit
      in_port[2] = 1'b1;
      repeat (17) tick();
      bus_wr(2'b01, 3'd3, 32'h006);
      bus_rd(3'd3); check_eq("collision_cap", readdata, 32'h004);
      bus_rd(3'd0); check_eq("collision_data", readdata, 32'h007);

      // mask write sets/clears irq without touching captures
      bus_wr(2'b01, 3'd2, 32'h004);
      check_eq("mask_irq_on", {31'b0, irq}, 32'h1);
      bus_wr(2'b01, 3'd2, 32'h001);
      check_eq("mask_irq_off", {31'b0, irq}, 32'h0);
      bus_rd(3'd3); check_eq("mask_keeps_cap", readdata, 32'h004);

      // bypass on channel 2
      bus_wr(2'b01, 3'd4, 32'h3FB);
      bus_wr(2'b01, 3'd3, 32'h004);
      bus_rd(3'd3); check_eq("bypass_clr", readdata, 32'h0);
      bus_rd(3'd4); check_eq("bypass_db_en", readdata, 32'h3FB);
      address = 3'd0;
      in_port[2] = 1'b0;
      repeat (3) tick();
      check_eq("bypass_lag", readdata, 32'h007);
      tick();
      check_eq("bypass_data", readdata, 32'h003);
      bus_rd(3'd3); check_eq("bypass_fall_cap", readdata, 32'h004);
      bus_wr(2'b01, 3'd3, 32'h004);
      in_port[2] = 1'b1;
      tick();
      in_port[2] = 1'b0;
      repeat (5) tick();
      bus_rd(3'd3); check_eq("pulse_cap", readdata, 32'h004);
      bus_rd(3'd0); check_eq("pulse_data", readdata, 32'h003);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
